// File: rtl/cache_kv_controller.sv
// cache_kv_controller: key-value store controller with fully-associative lookup and round-robin eviction
module cache_kv_controller #(
  parameter int KEY_WIDTH   = 64,
  parameter int VALUE_WIDTH = 128,
  parameter int NUM_ENTRIES = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               req_valid_i,
  output logic                               req_ready_o,
  input  logic [1:0]                         req_op_i,
  input  logic [KEY_WIDTH-1:0]               req_key_i,
  input  logic [VALUE_WIDTH-1:0]             req_value_i,
  output logic                               resp_valid_o,
  input  logic                               resp_ready_i,
  output logic                               resp_hit_o,
  output logic                               resp_err_o,
  output logic [VALUE_WIDTH-1:0]             resp_value_o,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]   occupancy_o
);
  localparam int IW = $clog2(NUM_ENTRIES);
  localparam int OW = $clog2(NUM_ENTRIES+1);
  localparam logic [1:0] OP_GET = 2'b00;
  localparam logic [1:0] OP_PUT = 2'b01;
  localparam logic [1:0] OP_DEL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;
  typedef enum logic [1:0] {IDLE, LOOKUP, EXEC, RESP} state_t;
  state_t                   state;
  logic [1:0]               op_q;
  logic [KEY_WIDTH-1:0]     key_q;
  logic [VALUE_WIDTH-1:0]   val_q;
  logic                     hit_q;
  logic                     full_q;
  logic [IW-1:0]            hit_idx_q;
  logic [IW-1:0]            free_idx_q;
  logic [IW-1:0]            victim;
  logic [OW-1:0]            occ;
  logic [NUM_ENTRIES-1:0]   vld;
  logic [KEY_WIDTH-1:0]     keys [NUM_ENTRIES];
  logic [VALUE_WIDTH-1:0]   vals [NUM_ENTRIES];
  logic                     m_hit;
  logic [IW-1:0]            m_idx;
  logic [IW-1:0]            m_free;
  logic                     wr_en;
  logic [IW-1:0]            wr_idx;
  logic                     resp_valid;
  logic                     resp_hit;
  logic                     resp_err;
  logic [VALUE_WIDTH-1:0]   resp_value;
  logic                     req_ready;
  // parallel key compare; scanning downward leaves the lowest matching and lowest free index
  always_comb begin
    m_hit  = 1'b0;
    m_idx  = '0;
    m_free = '0;
    for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
      if (vld[i] && keys[i] == key_q) begin
        m_hit = 1'b1;
        m_idx = IW'(i);
      end
      if (!vld[i]) m_free = IW'(i);
    end
  end
  assign wr_en  = state == EXEC && op_q == OP_PUT;
  assign wr_idx = hit_q ? hit_idx_q : full_q ? victim : free_idx_q;
  // key/value arrays carry no reset; validity lives in vld
  always_ff @(posedge clk) begin
    if (wr_en) begin
      keys[wr_idx] <= key_q;
      vals[wr_idx] <= val_q;
    end
  end
  // control FSM, valid bits, occupancy, victim pointer and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= OP_GET;
      key_q      <= '0;
      val_q      <= '0;
      hit_q      <= 1'b0;
      full_q     <= 1'b0;
      hit_idx_q  <= '0;
      free_idx_q <= '0;
      victim     <= '0;
      occ        <= '0;
      vld        <= '0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_err   <= 1'b0;
      resp_value <= '0;
      req_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: if (req_valid_i) begin
          op_q      <= req_op_i;
          key_q     <= req_key_i;
          val_q     <= req_value_i;
          req_ready <= 1'b0;
          state     <= LOOKUP;
        end
        LOOKUP: begin
          hit_q      <= m_hit;
          hit_idx_q  <= m_idx;
          free_idx_q <= m_free;
          full_q     <= &vld;
          state      <= EXEC;
        end
        EXEC: begin
          resp_valid <= 1'b1;
          resp_err   <= op_q == OP_RSV;
          resp_hit   <= hit_q && op_q != OP_RSV;
          resp_value <= (op_q == OP_GET && hit_q) ? vals[hit_idx_q] : '0;
          if (op_q == OP_PUT && !hit_q) begin
            if (full_q) victim <= victim + IW'(1);
            else begin
              vld[free_idx_q] <= 1'b1;
              occ             <= occ + OW'(1);
            end
          end
          if (op_q == OP_DEL && hit_q) begin
            vld[hit_idx_q] <= 1'b0;
            occ            <= occ - OW'(1);
          end
          state <= RESP;
        end
        RESP: if (resp_ready_i) begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign req_ready_o  = req_ready;
  assign resp_valid_o = resp_valid;
  assign resp_hit_o   = resp_hit;
  assign resp_err_o   = resp_err;
  assign resp_value_o = resp_value;
  assign occupancy_o  = occ;
endmodule

// File: tb/tb_cache_kv_controller.sv
// tb_cache_kv_controller: scoreboard bench for the key-value controller with a 4-entry store
module tb_cache_kv_controller;
  localparam int KW = 64;
  localparam int VW = 128;
  localparam int N  = 4;
  localparam int OW = $clog2(N+1);
  localparam logic [1:0] GET = 2'b00, PUT = 2'b01, DEL = 2'b10, RSV = 2'b11;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'b00;
  logic [KW-1:0] req_key = '0;
  logic [VW-1:0] req_value = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic          resp_hit;
  logic          resp_err;
  logic [VW-1:0] resp_value;
  logic [OW-1:0] occupancy;
  typedef struct {
    string         name;
    logic          hit;
    logic          err;
    logic [VW-1:0] value;
    logic [OW-1:0] occ;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int n_cmp = 0;
  int n_bad = 0;
  cache_kv_controller #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .NUM_ENTRIES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_key_i(req_key), .req_value_i(req_value),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_hit_o(resp_hit), .resp_err_o(resp_err), .resp_value_o(resp_value),
    .occupancy_o(occupancy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  // monitor: pop the oldest expectation whenever a response handshake is presented
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: got hit=%0b err=%0b value=0x%0h expected no response", resp_hit, resp_err, resp_value);
      end else begin
        e = q.pop_front();
        chk({e.name, "_hit"}, VW'(resp_hit), VW'(e.hit));
        chk({e.name, "_err"}, VW'(resp_err), VW'(e.err));
        chk({e.name, "_value"}, resp_value, e.value);
        chk({e.name, "_occ"}, VW'(occupancy), VW'(e.occ));
      end
    end
  end
  task automatic wait_ready(input string name);
    for (int i = 0; i < 20 && !req_ready; i++) begin
      @(posedge clk);
      #1;
    end
    if (!req_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_ready_timeout: got req_ready=0 expected 1", name);
    end
  endtask
  task automatic do_op(input logic [1:0] op, input logic [KW-1:0] key, input logic [VW-1:0] val,
                       input logic hit, input logic err, input logic [VW-1:0] rv,
                       input logic [OW-1:0] occ, input string name, input int hold);
    int lat;
    wait_ready(name);
    q.push_back('{name, hit, err, rv, occ});
    req_valid  = 1'b1;
    req_op     = op;
    req_key    = key;
    req_value  = val;
    resp_ready = hold == 0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (resp_valid) break;
    end
    chk({name, "_latency"}, VW'(lat), VW'(3));
    for (int h = 0; h < hold; h++) begin
      chk({name, "_hold"}, VW'({resp_valid, req_ready, resp_err, resp_hit, resp_value}),
          VW'({1'b1, 1'b0, err, hit, rv}));
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_op    = PUT;
      req_key   = 64'h9;
      req_value = 128'h999;
      @(negedge clk);
    end
    if (hold > 0) begin
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      resp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    wait_ready(name);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", VW'({req_ready, resp_valid, resp_hit, resp_err, occupancy}), VW'({1'b1, 1'b0, 1'b0, 1'b0, 3'd0}));
    chk("reset_value", resp_value, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op(GET, 64'h5, '0,      1'b0, 1'b0, '0,      3'd0, "get5_empty", 0);
    do_op(PUT, 64'h5, 128'hAB, 1'b0, 1'b0, '0,      3'd1, "put5_ab", 0);
    do_op(GET, 64'h5, '0,      1'b1, 1'b0, 128'hAB, 3'd1, "get5_ab", 0);
    do_op(PUT, 64'h5, 128'hCD, 1'b1, 1'b0, '0,      3'd1, "put5_cd", 0);
    do_op(GET, 64'h5, '0,      1'b1, 1'b0, 128'hCD, 3'd1, "get5_cd", 0);
    do_op(DEL, 64'h5, '0,      1'b1, 1'b0, '0,      3'd0, "del5", 0);
    do_op(PUT, 64'h1, 128'h101, 1'b0, 1'b0, '0, 3'd1, "put1", 0);
    do_op(PUT, 64'h2, 128'h102, 1'b0, 1'b0, '0, 3'd2, "put2", 0);
    do_op(PUT, 64'h3, 128'h103, 1'b0, 1'b0, '0, 3'd3, "put3", 0);
    do_op(PUT, 64'h4, 128'h104, 1'b0, 1'b0, '0, 3'd4, "put4", 0);
    do_op(PUT, 64'h5, 128'h105, 1'b0, 1'b0, '0, 3'd4, "put5_evict0", 0);
    do_op(GET, 64'h1, '0, 1'b0, 1'b0, '0,       3'd4, "get1_evicted", 0);
    do_op(GET, 64'h5, '0, 1'b1, 1'b0, 128'h105, 3'd4, "get5_new", 0);
    do_op(PUT, 64'h6, 128'h106, 1'b0, 1'b0, '0, 3'd4, "put6_evict1", 0);
    do_op(GET, 64'h2, '0, 1'b0, 1'b0, '0,       3'd4, "get2_evicted", 0);
    do_op(GET, 64'h6, '0, 1'b1, 1'b0, 128'h106, 3'd4, "get6", 0);
    do_op(DEL, 64'h3, '0, 1'b1, 1'b0, '0, 3'd3, "del3_hit", 0);
    do_op(DEL, 64'h3, '0, 1'b0, 1'b0, '0, 3'd3, "del3_miss", 0);
    do_op(PUT, 64'h7, 128'h107, 1'b0, 1'b0, '0, 3'd4, "put7_free", 0);
    do_op(GET, 64'h4, '0, 1'b1, 1'b0, 128'h104, 3'd4, "get4", 0);
    do_op(GET, 64'h5, '0, 1'b1, 1'b0, 128'h105, 3'd4, "get5", 0);
    do_op(GET, 64'h7, '0, 1'b1, 1'b0, 128'h107, 3'd4, "get7", 0);
    do_op(PUT, 64'h8, 128'h108, 1'b0, 1'b0, '0, 3'd4, "put8_evict2", 0);
    do_op(GET, 64'h7, '0, 1'b0, 1'b0, '0,       3'd4, "get7_evicted", 0);
    do_op(GET, 64'h4, '0, 1'b1, 1'b0, 128'h104, 3'd4, "get4_kept", 0);
    do_op(RSV, 64'h5, 128'hEE, 1'b0, 1'b1, '0, 3'd4, "rsv5_hold", 10);
    do_op(GET, 64'h5, '0, 1'b1, 1'b0, 128'h105, 3'd4, "get5_after_rsv", 0);
    do_op(GET, 64'h9, '0, 1'b0, 1'b0, '0,       3'd4, "get9_ignored", 0);
    wait_ready("put77_reset");
    req_valid = 1'b1;
    req_op    = PUT;
    req_key   = 64'h77;
    req_value = 128'h777;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("exec_reset", VW'({resp_valid, req_ready, occupancy}), VW'({1'b0, 1'b1, 3'd0}));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op(GET, 64'h77, '0, 1'b0, 1'b0, '0, 3'd0, "get77_after_reset", 0);
    do_op(GET, 64'h5,  '0, 1'b0, 1'b0, '0, 3'd0, "get5_after_reset", 0);
    repeat (3) @(posedge clk);
    chk("queue_drained", VW'(q.size()), VW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cache_kv_controller.md
# cache_kv_controller

Key-value storage controller sitting directly downstream of the OBI cache interface. It accepts one latched cache operation at a time (GET, PUT, DEL on a key/value pair) over a valid/ready handshake and executes it against a small fully-associative register store. It returns hit/error status and read data over a second valid/ready handshake, which the interface forwards to the OBI master. Capacity overflow on PUT is handled by round-robin eviction.

## Interface
- KEY_WIDTH, 64, key width in bits
- VALUE_WIDTH, 128, value width in bits
- NUM_ENTRIES, 8, number of store entries (power of two, >= 2)
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req_valid_i  input  1  request valid from interface
- req_ready_o  output  1  controller can accept a request
- req_op_i  input  2  00 GET, 01 PUT, 10 DEL, 11 reserved
- req_key_i  input  KEY_WIDTH  request key
- req_value_i  input  VALUE_WIDTH  write data (PUT only)
- resp_valid_o  output  1  response valid
- resp_ready_i  input  1  interface accepts response
- resp_hit_o  output  1  key was present at lookup
- resp_err_o  output  1  reserved opcode received
- resp_value_o  output  VALUE_WIDTH  read data
- occupancy_o  output  $clog2(NUM_ENTRIES+1)  number of valid entries

## Operation
- Storage: per entry a valid bit, key register and value register. Keys are unique; if multiple matches ever occur, the lowest index wins.
- FSM states: IDLE, LOOKUP, EXEC, RESP.
- IDLE:
  - req_ready_o=1; all other states drive req_ready_o=0.
  - On req_valid_i&&req_ready_o, latch op/key/value and go to LOOKUP.
- LOOKUP (1 cycle):
  - Parallel compare of latched key against all valid entries.
  - Register hit flag and hit index, lowest invalid index (free index), and full flag.
  - Go to EXEC.
- EXEC (1 cycle), then go to RESP:
  - GET: hit → resp_value=stored value; miss → resp_value=0.
  - PUT hit: overwrite value at hit index; occupancy unchanged.
  - PUT miss, not full: write key/value at free index, set valid, occupancy+1.
  - PUT miss, full: overwrite entry at victim pointer; pointer advances by 1 mod NUM_ENTRIES. Occupancy unchanged.
  - DEL hit: clear valid, occupancy−1. DEL miss: no change.
  - Op 11: no state change; resp_err=1, resp_hit=0, resp_value=0.
  - resp_value=0 for PUT and DEL.
- RESP:
  - resp_valid_o=1; resp_hit_o/resp_err_o/resp_value_o held stable until resp_ready_i.
  - On resp_valid_o&&resp_ready_i, go to IDLE.
- resp_hit_o semantics: GET/PUT/DEL = key present at LOOKUP.
- Victim pointer moves only on full-miss PUT. Free slots are always preferred over eviction, even if the pointer points elsewhere.

## Timing
- Request handshake at edge T: LOOKUP during cycle T+1, EXEC T+2, resp_valid_o high from cycle T+3.
- Minimum spacing between accepted requests is 4 cycles (response accepted in T+3 → req_ready_o high in T+4).
- Response backpressure: RESP held indefinitely; no new request accepted meanwhile.
- Store, occupancy and victim pointer update on the EXEC→RESP edge. A GET issued after a PUT's response is accepted sees the new data.
- Reset (asynchronous, any state):
  - state=IDLE, all valid bits=0, victim pointer=0, occupancy_o=0.
  - resp_valid_o=0, resp_hit_o=0, resp_err_o=0, resp_value_o=0, req_ready_o=1.
  - In-flight request and pending response are discarded.
  - Key/value arrays need not be reset.
- req_* inputs are ignored outside IDLE.

## Test plan
- Reset, then GET key 0x5 → resp after 3 cycles: hit=0, err=0, value=0; occupancy_o=0.
- PUT key 0x5 value 0xAB, then GET 0x5 → PUT resp hit=0, occupancy 1; GET resp hit=1, value 0xAB. PUT 0x5 value 0xCD → hit=1, occupancy stays 1; GET → 0xCD.
- NUM_ENTRIES=4: PUT keys 1,2,3,4 (occupancy 4), PUT key 5 → evicts entry 0 (key 1); GET 1 → hit=0; GET 5 → hit=1. PUT 6 → evicts entry 1 (key 2).
- DEL key 3 → hit=1, occupancy 3; DEL 3 again → hit=0; PUT 7 fills freed slot 2, no eviction (GET 4 and GET 5 still hit).
- Op 11 with key 0x5 → err=1, hit=0, value=0, store unchanged. Hold resp_ready_i=0 for 10 cycles → resp outputs stable, req_ready_o=0 throughout.
- Assert rst_n low during EXEC of a PUT → resp_valid_o=0 immediately, occupancy_o=0; after release, GET of that key → hit=0.
